// File: rtl/sm_fetch_prefetch.sv
// sm_fetch_prefetch: sequential instruction prefetch FIFO with redirect flush
module sm_fetch_prefetch #(
  parameter int DEPTH = 4,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] cpuAddr,
  output logic [31:0]   cpuData,
  output logic          cpuValid,
  input  logic          cpuAdvance,
  output logic [AW-1:0] memAddr,
  output logic          memReq,
  input  logic          memGnt,
  input  logic [31:0]   memRdata,
  input  logic          memRvalid
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [31:0]   fifo [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, inflight, discard;
  logic [AW-1:0] head_addr, fetch_addr;
  logic          redirect, accept, pop, wr;
  // hit/redirect decode, request gating by slot reservation, response routing
  always_comb begin
    redirect = !rst && (cpuAddr != head_addr);
    cpuValid = !rst && !redirect && (count != '0);
    cpuData  = cpuValid ? fifo[rd_ptr] : '0;
    memReq   = !rst && !redirect && (({1'b0, count} + {1'b0, inflight}) < (CW+1)'(DEPTH));
    memAddr  = rst ? '0 : fetch_addr;
    accept   = memReq && memGnt;
    pop      = cpuValid && cpuAdvance;
    wr       = memRvalid && !redirect && (discard == '0);
  end
  // pointers, counters and addresses; a redirect drops everything still in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      inflight   <= '0;
      discard    <= '0;
      head_addr  <= '0;
      fetch_addr <= '0;
    end else if (redirect) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      inflight   <= inflight - CW'(memRvalid);
      discard    <= inflight - CW'(memRvalid);
      head_addr  <= cpuAddr;
      fetch_addr <= cpuAddr;
    end else begin
      if (accept) fetch_addr <= fetch_addr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (pop) head_addr <= head_addr + AW'(1);
      if (wr) wr_ptr <= wr_ptr + PW'(1);
      if (memRvalid && discard != '0) discard <= discard - CW'(1);
      inflight <= inflight + CW'(accept) - CW'(memRvalid);
      count    <= count + CW'(wr) - CW'(pop);
    end
  end
  // FIFO storage; registered write, so new data is visible the next cycle
  always_ff @(posedge clk) begin
    if (!rst && wr) fifo[wr_ptr] <= memRdata;
  end
  // slot reservation keeps the FIFO from ever being written while full
  always_ff @(posedge clk) begin
    if (!rst && wr) assert (count != CW'(DEPTH));
  end
endmodule

// File: tb/tb_sm_fetch_prefetch.sv
// tb_sm_fetch_prefetch: scoreboard bench for the prefetch buffer
module tb_sm_fetch_prefetch;
  typedef struct { logic [31:0] a; int due; } req_t;
  logic        clk = 0, rst = 1;
  logic [31:0] cpuAddr = 0, cpuData, memAddr, memRdata = 0;
  logic        cpuValid, cpuAdvance = 0, memReq, memGnt = 1, memRvalid = 0;
  logic        last_fire = 0;
  int          n_chk = 0, n_fail = 0, cyc = 0, lat = 1;
  logic [31:0] exp_q[$], acc_q[$];
  req_t        pend[$];

  sm_fetch_prefetch #(.DEPTH(4), .AW(32)) dut (
    .clk(clk), .rst(rst), .cpuAddr(cpuAddr), .cpuData(cpuData), .cpuValid(cpuValid),
    .cpuAdvance(cpuAdvance), .memAddr(memAddr), .memReq(memReq), .memGnt(memGnt),
    .memRdata(memRdata), .memRvalid(memRvalid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] dat(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // fixed-latency pipelined in-order memory
  initial forever begin
    @(negedge clk);
    if (rst) pend.delete();
    else if (memReq && memGnt) begin
      pend.push_back('{a: memAddr, due: cyc + lat});
      acc_q.push_back(memAddr);
    end
    @(posedge clk);
    #1;
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      memRvalid = 1;
      memRdata = dat(pend[0].a);
      void'(pend.pop_front());
    end else begin
      memRvalid = 0;
      memRdata = 0;
    end
  end

  // scoreboard monitor: every consumed instruction is checked against the expected queue
  always @(negedge clk) begin
    last_fire = !rst && cpuValid && cpuAdvance;
    if (last_fire) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL cpu_unexpected: popped addr %h, none expected", cpuAddr);
      end else begin
        chk("cpu_addr", cpuAddr, exp_q[0]);
        chk("cpu_data", cpuData, dat(exp_q[0]));
        void'(exp_q.pop_front());
      end
    end
  end

  // CPU model: PC advances after each consumed instruction
  task automatic tick();
    @(posedge clk);
    #1;
    if (last_fire) cpuAddr = cpuAddr + 1;
  endtask

  task automatic reset_to(input logic [31:0] addr, input logic adv, input int l);
    rst = 1;
    cpuAddr = addr;
    cpuAdvance = adv;
    memGnt = 1;
    lat = l;
    exp_q.delete();
    tick();
    tick();
    @(negedge clk);
    chk("rst_valid", cpuValid, 0);
    chk("rst_req", memReq, 0);
    chk("rst_addr", memAddr, 0);
    chk("rst_data", cpuData, 0);
    tick();
    rst = 0;
    acc_q.delete();
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    cpuAdvance = 0;
    chk(nm, exp_q.size(), 0);
  endtask

  initial begin
    // 1: sequential streaming, latency 1
    reset_to(0, 1, 1);
    for (int i = 0; i < 12; i++) exp_q.push_back(i);
    @(negedge clk);
    chk("t1_req0", memReq, 1);
    chk("t1_addr0", memAddr, 0);
    tick();
    @(negedge clk);
    chk("t1_valid1", cpuValid, 0);
    tick();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("t1_stream", cpuValid, 1);
      tick();
    end
    drain("t1_drain");
    // 2: backpressure fills reservation, then resumes at 4
    reset_to(0, 0, 1);
    repeat (10) tick();
    chk("t2_nacc", acc_q.size(), 4);
    for (int i = 0; i < 4 && i < acc_q.size(); i++) chk("t2_acc", acc_q[i], i);
    @(negedge clk);
    chk("t2_req", memReq, 0);
    chk("t2_valid", cpuValid, 1);
    chk("t2_data", cpuData, dat(0));
    tick();
    for (int i = 0; i < 5; i++) exp_q.push_back(i);
    cpuAdvance = 1;
    drain("t2_drain");
    chk("t2_resume_n", acc_q.size() > 4, 1);
    if (acc_q.size() > 4) chk("t2_resume", acc_q[4], 4);
    // 3: grant stall holds memAddr
    reset_to(7, 1, 1);
    exp_q.push_back(7);
    memGnt = 0;
    @(negedge clk);
    chk("t3_redir_req", memReq, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_stall_req", memReq, 1);
      chk("t3_stall_addr", memAddr, 7);
      tick();
    end
    memGnt = 1;
    @(negedge clk);
    chk("t3_gnt_addr", memAddr, 7);
    tick();
    memGnt = 0;
    @(negedge clk);
    chk("t3_next_addr", memAddr, 8);
    chk("t3_nacc", acc_q.size(), 1);
    tick();
    memGnt = 1;
    drain("t3_drain");
    // 4: redirect with two requests in flight, latency 3
    reset_to(5, 1, 3);
    for (int i = 0; i < 3; i++) exp_q.push_back(32'h40 + i);
    repeat (3) tick();
    cpuAddr = 32'h40;
    @(negedge clk);
    chk("t4_redir_req", memReq, 0);
    chk("t4_redir_valid", cpuValid, 0);
    tick();
    for (int i = 4; i < 8; i++) begin
      @(negedge clk);
      chk("t4_wait", cpuValid, 0);
      if (i == 4) chk("t4_new_addr", memAddr, 32'h40);
      if (i == 4) chk("t4_new_req", memReq, 1);
      tick();
    end
    @(negedge clk);
    chk("t4_hit", cpuValid, 1);
    chk("t4_hit_data", cpuData, dat(32'h40));
    drain("t4_drain");
    // 5: redirect in the same cycle as a response, one more in flight
    reset_to(5, 1, 3);
    for (int i = 0; i < 2; i++) exp_q.push_back(32'h40 + i);
    repeat (3) tick();
    memGnt = 0;
    tick();
    cpuAddr = 32'h40;
    memGnt = 1;
    @(negedge clk);
    chk("t5_redir_req", memReq, 0);
    chk("t5_redir_valid", cpuValid, 0);
    tick();
    for (int i = 5; i < 9; i++) begin
      @(negedge clk);
      chk("t5_wait", cpuValid, 0);
      if (i == 5) chk("t5_new_addr", memAddr, 32'h40);
      tick();
    end
    @(negedge clk);
    chk("t5_hit", cpuValid, 1);
    chk("t5_hit_data", cpuData, dat(32'h40));
    drain("t5_drain");
    // 6: one-cycle reset pulse with three entries buffered
    reset_to(0, 0, 1);
    repeat (4) tick();
    rst = 1;
    @(negedge clk);
    chk("t6_rst_valid", cpuValid, 0);
    chk("t6_rst_req", memReq, 0);
    tick();
    rst = 0;
    @(negedge clk);
    chk("t6_req", memReq, 1);
    chk("t6_addr", memAddr, 0);
    chk("t6_empty", cpuValid, 0);
    tick();
    @(negedge clk);
    chk("t6_wait", cpuValid, 0);
    tick();
    @(negedge clk);
    chk("t6_valid", cpuValid, 1);
    chk("t6_data", cpuData, dat(0));
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
